// File: rtl/cpu_pipe_pkg.sv
`default_nettype none
// ============================================================
// Package : cpu_pipe_pkg
// Brief   : Shared pipeline-control types and constants.
// Rev     : 1.0
// ============================================================
package cpu_pipe_pkg;

  localparam int REG_ADDR_W = 4;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 4'h0;
  // Instruction word the pipeline registers load when flushed or bubbled.
  localparam logic [31:0] NOP_ENC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IMISS = 2'd1,
    ST_DMISS = 2'd2
  } pipe_state_e;

  function automatic logic src_hit(
    input logic                  uses,
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] dest
  );
    return uses && (src == dest);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stall_perf_counter.sv
`default_nettype none
// ============================================================
// Module : stall_perf_counter
// Brief  : Saturating up-counter with sticky reached-MAX flag.
// Rev    : 1.0
// ============================================================
module stall_perf_counter
  import cpu_pipe_pkg::*;
#(
  parameter int             W   = 16,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         hit_o
);

  logic [W-1:0] count_q, count_d;
  logic         hit_q, hit_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MAX)) begin
      count_d = count_q + W'(1);
    end
    // Flag rises on the same edge the count lands on MAX and only rst clears it.
    hit_d = hit_q | (count_d == MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      hit_q   <= hit_d;
    end
  end

  assign count_o = count_q;
  assign hit_o   = hit_q;

endmodule
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================
// Module : hazard_stall_unit
// Brief  : ID-stage stall/flush controller with cache-miss freeze,
//          stall-cycle counter and miss watchdog.
// Rev    : 1.0
// ============================================================
module hazard_stall_unit
  import cpu_pipe_pkg::*;
#(
  parameter bit EXMEM_FWD    = 1'b0,
  parameter int CNT_W        = 16,
  parameter int MISS_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rt,
  input  logic                  IF_ID_UsesRs,
  input  logic                  IF_ID_UsesRt,
  input  logic [REG_ADDR_W-1:0] ID_EX_WriteRegAddr,
  input  logic                  ID_EX_RegWrite,
  input  logic                  ID_EX_MemRead,
  input  logic                  ID_BranchTaken,
  input  logic                  ICacheMiss,
  input  logic                  DCacheMiss,
  output logic                  PC_Stall,
  output logic                  IF_ID_Stall,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Stall,
  output logic                  ID_EX_Bubble,
  output logic                  EX_MEM_Stall,
  output logic                  MEM_WB_Bubble,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic                  miss_err
);

  localparam int               TMR_W   = $clog2(MISS_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MISS_TIMEOUT);

  pipe_state_e      state_q, state_d;
  logic             w_gate;
  logic             w_hazard;
  logic             w_branch;
  logic             w_unused_stall_sat;
  logic [TMR_W-1:0] w_unused_miss_tmr;

  // With EX/MEM forwarding only a load result is still unavailable to ID.
  assign w_gate   = EXMEM_FWD ? ID_EX_MemRead : 1'b1;
  assign w_hazard = ID_EX_RegWrite && (ID_EX_WriteRegAddr != REG_ZERO) && w_gate &&
                    (src_hit(IF_ID_UsesRs, IF_ID_Rs, ID_EX_WriteRegAddr) ||
                     src_hit(IF_ID_UsesRt, IF_ID_Rt, ID_EX_WriteRegAddr));
  assign w_branch = ID_BranchTaken && !w_hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (DCacheMiss) begin
      state_d = ST_DMISS;
    end else begin
      unique case (state_q)
        ST_RUN:   state_d = (ICacheMiss && !w_hazard && !ID_BranchTaken) ? ST_IMISS : ST_RUN;
        // A taken branch redirects the PC, so the outstanding fetch is abandoned.
        ST_IMISS,
        ST_DMISS: state_d = (ICacheMiss && !w_branch) ? ST_IMISS : ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // The cycle a miss input drops already behaves as the following state,
  // so the controls follow the live inputs rather than the registered state.
  always_comb begin
    PC_Stall      = 1'b0;
    IF_ID_Stall   = 1'b0;
    IF_ID_Flush   = 1'b0;
    ID_EX_Stall   = 1'b0;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_Stall  = 1'b0;
    MEM_WB_Bubble = 1'b0;
    if (rst) begin
      IF_ID_Flush   = 1'b1;
      ID_EX_Bubble  = 1'b1;
      MEM_WB_Bubble = 1'b1;
    end else if (DCacheMiss) begin
      PC_Stall      = 1'b1;
      IF_ID_Stall   = 1'b1;
      ID_EX_Stall   = 1'b1;
      EX_MEM_Stall  = 1'b1;
      MEM_WB_Bubble = 1'b1;
    end else if (w_hazard) begin
      PC_Stall      = 1'b1;
      IF_ID_Stall   = 1'b1;
      ID_EX_Bubble  = 1'b1;
    end else if (ID_BranchTaken) begin
      IF_ID_Flush   = 1'b1;
    end else if (ICacheMiss) begin
      PC_Stall      = 1'b1;
      IF_ID_Flush   = 1'b1;
    end
  end

  stall_perf_counter #(
    .W   (CNT_W),
    .MAX ({CNT_W{1'b1}})
  ) u_stall_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (1'b0),
    .inc_i   (PC_Stall),
    .count_o (stall_cycles),
    .hit_o   (w_unused_stall_sat)
  );

  stall_perf_counter #(
    .W   (TMR_W),
    .MAX (TMR_MAX)
  ) u_miss_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (state_q == ST_RUN),
    .inc_i   (state_q != ST_RUN),
    .count_o (w_unused_miss_tmr),
    .hit_o   (miss_err)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================
// Module : tb_hazard_stall_unit
// Brief  : Directed scoreboard bench; two instances differ in EXMEM_FWD.
// Rev    : 1.0
// ============================================================
module tb_hazard_stall_unit;

  // Control vector order: {PC, IFID_St, IFID_Fl, IDEX_St, IDEX_Bub, EXMEM_St, MEMWB_Bub}
  localparam logic [6:0] NRM = 7'b0000000;
  localparam logic [6:0] HZ  = 7'b1100100;
  localparam logic [6:0] BR  = 7'b0010000;
  localparam logic [6:0] IM  = 7'b1010000;
  localparam logic [6:0] DM  = 7'b1101011;
  localparam logic [6:0] RS  = 7'b0010101;

  typedef struct {
    string       tag;
    logic [6:0]  c0;
    logic [6:0]  c1;
    logic [15:0] n0;
    logic [15:0] n1;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] IF_ID_Rs, IF_ID_Rt, ID_EX_WriteRegAddr;
  logic       IF_ID_UsesRs, IF_ID_UsesRt, ID_EX_RegWrite, ID_EX_MemRead;
  logic       ID_BranchTaken, ICacheMiss, DCacheMiss;

  logic        pc0, ifs0, iff0, ids0, idb0, exs0, mwb0, err0;
  logic        pc1, ifs1, iff1, ids1, idb1, exs1, mwb1, err1;
  logic [15:0] cnt0, cnt1;
  logic [6:0]  obs0, obs1;

  assign obs0 = {pc0, ifs0, iff0, ids0, idb0, exs0, mwb0};
  assign obs1 = {pc1, ifs1, iff1, ids1, idb1, exs1, mwb1};

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_cnt0 = '0;
  logic [15:0] m_cnt1 = '0;

  hazard_stall_unit #(.EXMEM_FWD(1'b0), .CNT_W(16), .MISS_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
    .IF_ID_UsesRs(IF_ID_UsesRs), .IF_ID_UsesRt(IF_ID_UsesRt),
    .ID_EX_WriteRegAddr(ID_EX_WriteRegAddr), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_BranchTaken(ID_BranchTaken),
    .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
    .PC_Stall(pc0), .IF_ID_Stall(ifs0), .IF_ID_Flush(iff0),
    .ID_EX_Stall(ids0), .ID_EX_Bubble(idb0), .EX_MEM_Stall(exs0),
    .MEM_WB_Bubble(mwb0), .stall_cycles(cnt0), .miss_err(err0)
  );

  hazard_stall_unit #(.EXMEM_FWD(1'b1), .CNT_W(16), .MISS_TIMEOUT(8)) dut_fwd (
    .clk(clk), .rst(rst),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
    .IF_ID_UsesRs(IF_ID_UsesRs), .IF_ID_UsesRt(IF_ID_UsesRt),
    .ID_EX_WriteRegAddr(ID_EX_WriteRegAddr), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_BranchTaken(ID_BranchTaken),
    .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
    .PC_Stall(pc1), .IF_ID_Stall(ifs1), .IF_ID_Flush(iff1),
    .ID_EX_Stall(ids1), .ID_EX_Bubble(idb1), .EX_MEM_Stall(exs1),
    .MEM_WB_Bubble(mwb1), .stall_cycles(cnt1), .miss_err(err1)
  );

  task automatic clear_in();
    IF_ID_Rs = '0; IF_ID_Rt = '0; IF_ID_UsesRs = 1'b0; IF_ID_UsesRt = 1'b0;
    ID_EX_WriteRegAddr = '0; ID_EX_RegWrite = 1'b0; ID_EX_MemRead = 1'b0;
    ID_BranchTaken = 1'b0; ICacheMiss = 1'b0; DCacheMiss = 1'b0;
  endtask

  task automatic compare();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (obs0 === e.c0) else begin
      errors++; $error("FAIL %s ctl_nofwd observed=%b expected=%b", e.tag, obs0, e.c0);
    end
    checks++;
    assert (obs1 === e.c1) else begin
      errors++; $error("FAIL %s ctl_fwd observed=%b expected=%b", e.tag, obs1, e.c1);
    end
    checks++;
    assert (cnt0 === e.n0) else begin
      errors++; $error("FAIL %s cnt_nofwd observed=%0d expected=%0d", e.tag, cnt0, e.n0);
    end
    checks++;
    assert (cnt1 === e.n1) else begin
      errors++; $error("FAIL %s cnt_fwd observed=%0d expected=%0d", e.tag, cnt1, e.n1);
    end
    checks++;
    assert (err0 === e.err) else begin
      errors++; $error("FAIL %s miss_err_nofwd observed=%b expected=%b", e.tag, err0, e.err);
    end
    checks++;
    assert (err1 === e.err) else begin
      errors++; $error("FAIL %s miss_err_fwd observed=%b expected=%b", e.tag, err1, e.err);
    end
  endtask

  // Inputs are already set for this cycle; push expectation, sample mid-cycle.
  task automatic step(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                      input logic eerr);
    exp_t e;
    e.tag = tag; e.c0 = e0; e.c1 = e1; e.n0 = m_cnt0; e.n1 = m_cnt1; e.err = eerr;
    sb.push_back(e);
    if (rst) begin
      m_cnt0 = '0;
      m_cnt1 = '0;
    end else begin
      if (e0[6]) m_cnt0 = m_cnt0 + 16'd1;
      if (e1[6]) m_cnt1 = m_cnt1 + 16'd1;
    end
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    DCacheMiss = 1'b1; ID_BranchTaken = 1'b1;
    step("rst_hold", RS, RS, 1'b0);

    rst = 1'b0; clear_in();
    step("idle", NRM, NRM, 1'b0);

    ID_EX_WriteRegAddr = 4'd3; ID_EX_RegWrite = 1'b1; ID_EX_MemRead = 1'b1;
    IF_ID_Rt = 4'd3; IF_ID_UsesRt = 1'b1;
    step("load_use", HZ, HZ, 1'b0);
    ID_EX_WriteRegAddr = 4'd0; ID_EX_RegWrite = 1'b0; ID_EX_MemRead = 1'b0;
    step("load_use_bubble", NRM, NRM, 1'b0);

    ID_EX_WriteRegAddr = 4'd0; ID_EX_RegWrite = 1'b1; ID_EX_MemRead = 1'b1;
    IF_ID_Rt = 4'd0; IF_ID_UsesRt = 1'b1;
    step("load_r0", NRM, NRM, 1'b0);

    clear_in();
    ID_EX_WriteRegAddr = 4'd5; ID_EX_RegWrite = 1'b1;
    IF_ID_Rs = 4'd5; IF_ID_UsesRs = 1'b1;
    step("alu_use", HZ, NRM, 1'b0);
    IF_ID_UsesRs = 1'b0;
    step("alu_no_use", NRM, NRM, 1'b0);

    clear_in();
    ID_BranchTaken = 1'b1; ICacheMiss = 1'b1;
    step("br_imiss", BR, BR, 1'b0);
    clear_in();
    step("br_after", NRM, NRM, 1'b0);

    ID_EX_WriteRegAddr = 4'd3; ID_EX_RegWrite = 1'b1; ID_EX_MemRead = 1'b1;
    IF_ID_Rt = 4'd3; IF_ID_UsesRt = 1'b1; ID_BranchTaken = 1'b1;
    step("br_hazard", HZ, HZ, 1'b0);
    clear_in();
    step("idle2", NRM, NRM, 1'b0);

    DCacheMiss = 1'b1;
    for (int i = 0; i < 5; i++) step($sformatf("dmiss_%0d", i), DM, DM, 1'b0);
    DCacheMiss = 1'b0; ICacheMiss = 1'b1;
    step("dmiss_exit_imiss", IM, IM, 1'b0);
    ICacheMiss = 1'b0;
    step("imiss_done", NRM, NRM, 1'b0);

    ICacheMiss = 1'b1;
    step("ov_imiss", IM, IM, 1'b0);
    DCacheMiss = 1'b1;
    step("ov_dmiss", DM, DM, 1'b0);
    DCacheMiss = 1'b0;
    step("ov_back_imiss", IM, IM, 1'b0);
    ICacheMiss = 1'b0;
    step("ov_run", NRM, NRM, 1'b0);
    step("ov_idle", NRM, NRM, 1'b0);

    DCacheMiss = 1'b1;
    for (int i = 0; i < 8; i++) step($sformatf("wd_dmiss_%0d", i), DM, DM, 1'b0);
    DCacheMiss = 1'b0;
    step("wd_release", NRM, NRM, 1'b0);
    step("wd_err_set", NRM, NRM, 1'b1);
    step("wd_err_hold", NRM, NRM, 1'b1);

    DCacheMiss = 1'b1;
    step("rst_pre_dmiss", DM, DM, 1'b1);
    rst = 1'b1;
    step("rst_mid_dmiss", RS, RS, 1'b1);
    rst = 1'b0; DCacheMiss = 1'b0;
    step("post_rst", NRM, NRM, 1'b0);
    step("post_rst_idle", NRM, NRM, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
